// File: rtl/sdp_ram_stream_reader_if.sv
// ============================================================================
// Module      : sdp_ram_stream_reader_if
// Description : Command and output-stream bundle for sdp_ram_stream_reader.
//               Command channel: cmd_valid / cmd_ready / cmd_addr / cmd_len.
//               Output stream  : m_valid / m_ready / m_data (+ m_last).
//               Modport master : the reader itself (accepts commands,
//                                produces the word stream).
//               Modport slave  : the peer (issues commands, consumes words).
//               Optional macro : SDP_RAM_READER_LAST_EN adds m_last.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdp_ram_stream_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
`ifdef SDP_RAM_READER_LAST_EN
  logic                  m_last;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, m_ready,
    output cmd_ready, m_valid, m_data, m_last
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, m_ready,
    input  cmd_ready, m_valid, m_data, m_last
  );
`else
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, m_ready,
    output cmd_ready, m_valid, m_data
  );
  modport slave (
    output cmd_valid, cmd_addr, cmd_len, m_ready,
    input  cmd_ready, m_valid, m_data
  );
`endif
endinterface

`default_nettype wire

// File: rtl/sdp_ram_stream_reader.sv
// ============================================================================
// Module      : sdp_ram_stream_reader
// Description : Read-side controller for a byte-write simple-dual-port RAM.
//               Takes a (start address, word count) command, drives the RAM
//               read port, absorbs the RAM's 1-cycle registered read latency
//               and emits the words in address order on a valid/ready stream
//               through a 3-entry buffer. Sustains 1 word/cycle with m_ready
//               held high. Single clock (the RAM's rd_clk).
// Ports       : clk            - clock (RAM rd_clk)
//               rst_n          - asynchronous active-low reset
//               bus            - sdp_ram_stream_reader_if.master
//                                (cmd_valid/ready/addr/len, m_valid/ready/
//                                data, m_last when enabled)
//               ram_rd_address - RAM read address
//               ram_rd_data    - RAM read data, valid 1 cycle after address
//               busy           - high while not idle
//               done           - 1-cycle pulse when a command completes
// Macro       : SDP_RAM_READER_LAST_EN - adds m_last marking the final word
//               of each command.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_ram_stream_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  sdp_ram_stream_reader_if.master    bus,
  output logic [ADDR_WIDTH-1:0]      ram_rd_address,
  input  wire logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                       busy,
  output logic                       done
);

  localparam int C_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_remain;
  logic                  r_pend;
  logic [DATA_WIDTH-1:0] r_buf [0:C_DEPTH-1];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;
  logic [1:0]            r_count;
  logic                  r_cmd_ready;
  logic                  r_busy;
  logic                  r_done;
`ifdef SDP_RAM_READER_LAST_EN
  logic [C_DEPTH-1:0]    r_buf_last;
  logic                  r_pend_last;
`endif

  logic w_cmd_fire;
  logic w_pop;
  logic w_push;
  logic w_issue;
  logic w_final_issue;
  logic w_drained;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(C_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_cmd_fire    = bus.cmd_valid && r_cmd_ready;
  assign w_pop         = (r_count != 2'd0) && bus.m_ready;
  // The word addressed last cycle is on ram_rd_data now.
  assign w_push        = r_pend;
  // Counting the in-flight read as occupied guarantees a free slot when it
  // lands, even if nothing is popped in the meantime.
  assign w_issue       = (r_state == ST_READ) &&
                         (({1'b0, r_count} + {2'b00, r_pend}) < 3'd3);
  assign w_final_issue = w_issue && (r_remain == LEN_WIDTH'(1));
  // Buffer is empty after this cycle's pop and nothing is in flight, so done
  // lands the cycle after the last beat.
  assign w_drained     = !r_pend &&
                         ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

  // The address register doubles as the RAM read address; outside an issue
  // cycle the RAM reads a harmless, ignored word.
  assign ram_rd_address = r_addr;
  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.m_valid    = (r_count != 2'd0);
  assign bus.m_data     = r_buf[r_rd_ptr];
  assign busy           = r_busy;
  assign done           = r_done;
`ifdef SDP_RAM_READER_LAST_EN
  assign bus.m_last     = r_buf_last[r_rd_ptr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_remain    <= '0;
      r_pend      <= 1'b0;
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 2'd0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < C_DEPTH; i++) begin
        r_buf[i] <= '0;
      end
`ifdef SDP_RAM_READER_LAST_EN
      r_buf_last  <= '0;
      r_pend_last <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_pend <= w_issue;
`ifdef SDP_RAM_READER_LAST_EN
      r_pend_last <= w_final_issue;
`endif

      // Buffer write / read pointers and occupancy.
      if (w_push) begin
        r_buf[r_wr_ptr] <= ram_rd_data;
`ifdef SDP_RAM_READER_LAST_EN
        r_buf_last[r_wr_ptr] <= r_pend_last;
`endif
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      // Command sequencing.
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_fire) begin
            if (bus.cmd_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_addr      <= bus.cmd_addr;
              r_remain    <= bus.cmd_len;
              r_state     <= ST_READ;
              r_cmd_ready <= 1'b0;
              r_busy      <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_issue) begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_remain <= r_remain - LEN_WIDTH'(1);
            if (w_final_issue) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state     <= ST_IDLE;
            r_done      <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdp_ram_stream_reader.sv
// ============================================================================
// Module      : tb_sdp_ram_stream_reader
// Description : Directed self-checking bench for sdp_ram_stream_reader with a
//               behavioural 1-cycle-latency RAM preloaded mem[i]=16'hA000+i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sdp_ram_stream_reader;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int LW = AW + 1;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] ram_rd_address;
  logic [DW-1:0] ram_rd_data;
  logic          busy;
  logic          done;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_total = 0;
  int n_bad   = 0;

  sdp_ram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  sdp_ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.master),
    .ram_rd_address (ram_rd_address),
    .ram_rd_data    (ram_rd_data),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAM model.
  always @(posedge clk) ram_rd_data <= mem[ram_rd_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int addr);
    return 16'hA000 + 16'((addr) % (1 << AW));
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_rd_addr"}, ram_rd_address, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef SDP_RAM_READER_LAST_EN
    chk({tag, "_m_last"}, bus.m_last, 0);
`endif
  endtask

  // Offer a command (accepted at the next edge); returns at cycle 1.
  task automatic send_cmd(input int addr, input int len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = AW'(addr);
    bus.cmd_len   = LW'(len);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Run a command and collect its beats. mode 0: always ready;
  // mode 1: m_ready pattern 1,0,0,1 repeating.
  task automatic run_burst(input string tag, input int addr, input int len, input int mode);
    int beats;
    int dones;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    beats = 0;
    dones = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    send_cmd(addr, len);
    for (int k = 0; k < 80 && dones == 0; k++) begin
      bus.m_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      if (prev_stall) begin
        chk({tag, "_hold_valid"}, bus.m_valid, 1);
        chk({tag, "_hold_data"}, bus.m_data, prev_data);
      end
      if (done) dones++;
      if (bus.m_valid && bus.m_ready) begin
        chk({tag, "_data"}, bus.m_data, exp_word(addr + beats));
`ifdef SDP_RAM_READER_LAST_EN
        chk({tag, "_last"}, bus.m_last, (beats == len - 1));
`endif
        beats++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      @(posedge clk); #1;
    end
    chk({tag, "_beats"}, beats, len);
    chk({tag, "_done_seen"}, dones, 1);
    bus.m_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'hA000 + 16'(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.m_ready   = 1'b1;
    rst_n = 1'b1;

    // 1: async reset asserted mid-cycle.
    #2 rst_n = 1'b0;
    #1 reset_checks("rst0");
    #20 rst_n = 1'b1;

    // 2: addr 5 len 4, always ready, cycle-exact.
    send_cmd(5, 4);
    chk("t2_busy_c1", busy, 1);
    chk("t2_cmd_ready_c1", bus.cmd_ready, 0);
    chk("t2_valid_c1", bus.m_valid, 0);
    @(posedge clk); #1;
    chk("t2_valid_c2", bus.m_valid, 0);
    for (int c = 3; c <= 6; c++) begin
      @(posedge clk); #1;
      chk("t2_valid", bus.m_valid, 1);
      chk("t2_data", bus.m_data, exp_word(5 + c - 3));
      chk("t2_done_early", done, 0);
    end
    @(posedge clk); #1;
    chk("t2_done_c7", done, 1);
    chk("t2_busy_c7", busy, 0);
    chk("t2_valid_c7", bus.m_valid, 0);
    @(posedge clk); #1;
    chk("t2_done_c8", done, 0);

    // 3: same command with backpressure.
    run_burst("t3", 5, 4, 1);
    run_burst("t3b", 40, 9, 1);

    // 4: address wrap.
    run_burst("t4", 510, 4, 0);

    // 5: zero-length command.
    send_cmd(0, 0);
    chk("t5_done", done, 1);
    chk("t5_busy", busy, 0);
    chk("t5_valid", bus.m_valid, 0);
    chk("t5_cmd_ready", bus.cmd_ready, 1);
    @(posedge clk); #1;
    chk("t5_done_off", done, 0);
    chk("t5_valid_off", bus.m_valid, 0);

    // 6: reset after 2 of 8 beats, then a fresh command.
    send_cmd(20, 8);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_beat0", bus.m_data, exp_word(20));
    @(posedge clk); #1;
    chk("t6_beat1", bus.m_data, exp_word(21));
    @(posedge clk); #1;
    chk("t6_busy_pre", busy, 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("t6_rst");
    #3 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("t6_no_done", done, 0);
      chk("t6_no_valid", bus.m_valid, 0);
    end
    run_burst("t6", 0, 2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
